// File: rtl/mbs_mem_arbiter_if.sv
//==============================================================================
// mbs_mem_arbiter_if : request/grant/done bundle for one memory-bus master
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

interface mbs_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  done;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, done, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, done, rdata
   );
endinterface

`default_nettype wire

// File: rtl/mbs_mem_arbiter.sv
//==============================================================================
// mbs_mem_arbiter : CPU/DMA arbiter for a fixed-latency single-port memory bus
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module mbs_mem_arbiter #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_LAT       = 2,
   parameter int STARVE_LIMIT  = 4,
   parameter int DMA_MAX_BURST = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mbs_mem_arbiter_if.slave      cpu,
   mbs_mem_arbiter_if.slave      dma,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [3:0] c_mem_lat     = 4'(MEM_LAT);
   localparam logic [3:0] c_starve_lim  = 4'(STARVE_LIMIT);
   localparam logic [3:0] c_max_burst   = 4'(DMA_MAX_BURST);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_q,     state_d;
   logic [3:0]            wait_cnt_q,  wait_cnt_d;
   logic [3:0]            starve_cnt_q, starve_cnt_d;
   logic [3:0]            burst_cnt_q, burst_cnt_d;
   // Also identifies the owner of the transfer in flight, since it is
   // updated at the grant decision.
   logic                  last_dma_q,  last_dma_d;
   logic                  we_q,        we_d;
   logic                  cpu_gnt_q,   cpu_gnt_d;
   logic                  dma_gnt_q,   dma_gnt_d;
   logic                  cpu_done_q,  cpu_done_d;
   logic                  dma_done_q,  dma_done_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
   logic                  mem_re_q,    mem_re_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  dma_wins;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         starve_cnt_q <= '0;
         burst_cnt_q  <= '0;
         last_dma_q   <= 1'b0;
         we_q         <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         dma_gnt_q    <= 1'b0;
         cpu_done_q   <= 1'b0;
         dma_done_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         last_dma_q   <= last_dma_d;
         we_q         <= we_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dma_gnt_q    <= dma_gnt_d;
         cpu_done_q   <= cpu_done_d;
         dma_done_q   <= dma_done_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Every output is a flop, so each phase's outputs are set up one state early.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      starve_cnt_d = starve_cnt_q;
      burst_cnt_d  = burst_cnt_q;
      last_dma_d   = last_dma_q;
      we_d         = we_q;
      cpu_gnt_d    = cpu_gnt_q;
      dma_gnt_d    = dma_gnt_q;
      cpu_done_d   = 1'b0;
      dma_done_d   = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      dma_wins = dma.req &&
                 (!cpu.req ||
                  (last_dma_q && (burst_cnt_q < c_max_burst)) ||
                  (starve_cnt_q >= c_starve_lim));

      case (state_q)
         ST_IDLE: begin
            if (cpu.req || dma.req) begin
               state_d = ST_ISSUE;
               if (dma_wins) begin
                  we_d         = dma.we;
                  mem_addr_d   = dma.addr;
                  mem_wdata_d  = dma.wdata;
                  dma_gnt_d    = 1'b1;
                  starve_cnt_d = '0;
                  if (!last_dma_q)
                     burst_cnt_d = 4'd1;
                  else if (burst_cnt_q >= c_max_burst)
                     burst_cnt_d = c_max_burst;
                  else
                     burst_cnt_d = burst_cnt_q + 4'd1;
                  last_dma_d   = 1'b1;
               end else begin
                  we_d         = cpu.we;
                  mem_addr_d   = cpu.addr;
                  mem_wdata_d  = cpu.wdata;
                  cpu_gnt_d    = 1'b1;
                  if (dma.req && (starve_cnt_q < c_starve_lim))
                     starve_cnt_d = starve_cnt_q + 4'd1;
                  burst_cnt_d  = '0;
                  last_dma_d   = 1'b0;
               end
               mem_re_d = ~we_d;
               mem_we_d = we_d;
            end
         end

         ST_ISSUE: begin
            wait_cnt_d = c_mem_lat;
            state_d    = ST_WAIT;
         end

         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd1) begin
               state_d = ST_DONE;
               if (last_dma_q) begin
                  dma_done_d = 1'b1;
                  if (!we_q)
                     dma_rdata_d = mem_rdata;
               end else begin
                  cpu_done_d = 1'b1;
                  if (!we_q)
                     cpu_rdata_d = mem_rdata;
               end
            end
         end

         ST_DONE: begin
            cpu_gnt_d = 1'b0;
            dma_gnt_d = 1'b0;
            state_d   = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cpu.gnt   = cpu_gnt_q;
   assign cpu.done  = cpu_done_q;
   assign cpu.rdata = cpu_rdata_q;
   assign dma.gnt   = dma_gnt_q;
   assign dma.done  = dma_done_q;
   assign dma.rdata = dma_rdata_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mbs_mem_arbiter.sv
//==============================================================================
// tb_mbs_mem_arbiter : randomized bench for mbs_mem_arbiter against a
// transaction-level model. Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mbs_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int L  = 2;
   localparam int SL = 4;
   localparam int MB = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_re;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   mbs_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
   mbs_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma_if ();

   mbs_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(L),
      .STARVE_LIMIT(SL), .DMA_MAX_BURST(MB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu      (cpu_if),
      .dma      (dma_if),
      .mem_re   (mem_re),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] seed(input int idx);
      if (idx == 64) return 32'hDEADBEEF;
      return 32'(idx) * 32'h9E3779B9 + 32'h01234567;
   endfunction

   // Memory: returns data exactly L cycles after the read strobe, garbage otherwise.
   logic [31:0] ram [256];
   bit          ram_wr [256];
   bit          rd_pend = 1'b0;
   int          rd_due  = 0;
   logic [7:0]  rd_idx  = '0;

   function automatic logic [31:0] ram_val(input logic [7:0] idx);
      return ram_wr[idx] ? ram[idx] : seed(int'(idx));
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_pend <= 1'b0;
      end else begin
         if (rd_pend && cyc == rd_due) begin
            mem_rdata <= ram_val(rd_idx);
            rd_pend   <= 1'b0;
         end else begin
            mem_rdata <= $urandom;
         end
         if (mem_re) begin
            rd_pend <= 1'b1;
            rd_due  <= cyc + L;
            rd_idx  <= mem_addr[9:2];
         end
         if (mem_we) begin
            ram[mem_addr[9:2]]    <= mem_wdata;
            ram_wr[mem_addr[9:2]] <= 1'b1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   // Transaction-level reference model.
   bit          m_busy = 1'b0;
   int          m_start = 0;
   int          next_dec = 0;
   bit          m_dma = 1'b0;
   bit          m_we = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
   int          m_starve = 0, m_burst = 0;
   bit          m_last_dma = 1'b0;
   logic [31:0] exp_rd [2];
   logic [31:0] ref_mem [256];
   logic [1:0]  order_q [$];

   // Master stimulus state and knobs (index 0 = CPU, 1 = DMA).
   bit          req [2], pend [2];
   logic        we_v [2];
   logic [31:0] addr_v [2], wdata_v [2];
   int          free_at [2], pct [2], lim [2];
   bit          fix [2];
   logic        fwe [2];
   logic [31:0] faddr [2], fwdata [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      cpu_if.req = req[0]; cpu_if.we = we_v[0]; cpu_if.addr = addr_v[0]; cpu_if.wdata = wdata_v[0];
      dma_if.req = req[1]; dma_if.we = we_v[1]; dma_if.addr = addr_v[1]; dma_if.wdata = wdata_v[1];
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_cpu_gnt"},   32'(cpu_if.gnt),  0);
      chk({pfx, "_dma_gnt"},   32'(dma_if.gnt),  0);
      chk({pfx, "_cpu_done"},  32'(cpu_if.done), 0);
      chk({pfx, "_dma_done"},  32'(dma_if.done), 0);
      chk({pfx, "_mem_re"},    32'(mem_re),      0);
      chk({pfx, "_mem_we"},    32'(mem_we),      0);
      chk({pfx, "_mem_addr"},  mem_addr,         0);
      chk({pfx, "_mem_wdata"}, mem_wdata,        0);
      chk({pfx, "_cpu_rdata"}, cpu_if.rdata,     0);
      chk({pfx, "_dma_rdata"}, dma_if.rdata,     0);
   endtask

   task automatic check_outputs();
      int off;
      bit win, strobe, done;
      off    = cyc - m_start;
      win    = m_busy && off >= 1 && off <= L + 2;
      strobe = m_busy && off == 1;
      done   = m_busy && off == L + 2;
      if (done && !m_we) exp_rd[m_dma] = m_rd;
      chk("cpu_gnt",  32'(cpu_if.gnt),  32'(win && !m_dma));
      chk("dma_gnt",  32'(dma_if.gnt),  32'(win && m_dma));
      chk("cpu_done", 32'(cpu_if.done), 32'(done && !m_dma));
      chk("dma_done", 32'(dma_if.done), 32'(done && m_dma));
      chk("mem_re",   32'(mem_re),      32'(strobe && !m_we));
      chk("mem_we",   32'(mem_we),      32'(strobe && m_we));
      if (strobe) chk("mem_addr", mem_addr, m_addr);
      if (strobe && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("cpu_rdata", cpu_if.rdata, exp_rd[0]);
      chk("dma_rdata", dma_if.rdata, exp_rd[1]);
      if (done) begin
         m_busy         = 1'b0;
         pend[m_dma]    = 1'b0;
         free_at[m_dma] = cyc + 1;
         next_dec       = cyc + 1;
      end
   endtask

   task automatic update_masters();
      for (int i = 0; i < 2; i++) begin
         if (!pend[i] && cyc >= free_at[i]) begin
            if (lim[i] != 0 && int'($urandom_range(99)) < pct[i]) begin
               pend[i] = 1'b1;
               req[i]  = 1'b1;
               if (lim[i] > 0) lim[i]--;
               if (fix[i]) begin
                  we_v[i] = fwe[i]; addr_v[i] = faddr[i]; wdata_v[i] = fwdata[i];
               end else begin
                  we_v[i] = 1'($urandom_range(1)); addr_v[i] = $urandom; wdata_v[i] = $urandom;
               end
            end else begin
               req[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic decide();
      bit both, d;
      int idx;
      if (!m_busy && cyc >= next_dec && (req[0] || req[1])) begin
         both = req[0] && req[1];
         d    = req[1] && (!req[0] || (m_last_dma && m_burst < MB) || m_starve >= SL);
         if (d) begin
            m_starve = 0;
            m_burst  = m_last_dma ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 1;
         end else begin
            if (req[1]) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
            m_burst = 0;
         end
         m_last_dma = d;
         m_dma   = d;
         idx     = d ? 1 : 0;
         m_we    = we_v[idx];
         m_addr  = addr_v[idx];
         m_wdata = wdata_v[idx];
         if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
         else      m_rd = ref_mem[m_addr[9:2]];
         m_busy  = 1'b1;
         m_start = cyc;
         order_q.push_back({both, d});
      end
   endtask

   task automatic step_body();
      check_outputs();
      update_masters();
      decide();
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         step_body();
      end
   endtask

   // Grant winners of the first n contended decisions, first one in bit 11.
   function automatic logic [11:0] contended_order(input int n);
      logic [11:0] got;
      int k;
      got = '1;
      k   = 0;
      foreach (order_q[j]) begin
         if (order_q[j][1] && k < n) begin
            got[11-k] = order_q[j][0];
            k++;
         end
      end
      return got;
   endfunction

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 chk_zero("async_rst");
      m_busy     = 1'b0;
      m_starve   = 0;
      m_burst    = 0;
      m_last_dma = 1'b0;
      exp_rd     = '{32'h0, 32'h0};
      next_dec   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step_body();
   endtask

   initial begin
      bit found;
      logic [11:0] ord;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
      exp_rd = '{32'h0, 32'h0};
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; pend[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
         free_at[i] = 0; pct[i] = 0; lim[i] = -1; fix[i] = 1'b0;
         fwe[i] = 1'b0; faddr[i] = '0; fwdata[i] = '0;
      end
      drive();

      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      step_body();
      run(20);

      // Directed CPU read of 0x100.
      fix[0] = 1'b1; fwe[0] = 1'b0; faddr[0] = 32'h100; pct[0] = 100; lim[0] = 1;
      run(8);
      chk("cpu_read_data", cpu_if.rdata, 32'hDEADBEEF);

      // Continuous contention from a fresh arbitration history.
      fix[0] = 1'b0; pct = '{100, 100}; lim = '{-1, -1};
      order_q.delete();
      run(62);
      pct = '{0, 0};
      run(12);
      chk("contention_order", 32'(contended_order(12)), 32'h0C3);

      // Directed DMA write of 0x12345678 to 0x200.
      fix[1] = 1'b1; fwe[1] = 1'b1; faddr[1] = 32'h200; fwdata[1] = 32'h12345678;
      pct[1] = 100; lim[1] = 1;
      run(8);
      chk("dma_write_mem", ram_val(8'd128), 32'h12345678);

      // DMA-only stream, then a single CPU request must win the next slot.
      fix[1] = 1'b0; pct[1] = 100; lim[1] = -1;
      run(22);
      pct[0] = 100; lim[0] = 1;
      order_q.delete();
      run(20);
      chk("cpu_after_dma_stream", 32'(order_q.size() > 0 ? order_q[0] : 2'b11), 32'h2);
      chk("dma_follows_cpu",      32'(order_q.size() > 1 ? order_q[1] : 2'b11), 32'h1);
      pct = '{0, 0};
      run(12);

      // Random mix.
      pct = '{60, 60}; lim = '{-1, -1};
      run(300);
      pct = '{0, 0};
      run(15);

      // Reset in the first WAIT cycle of a CPU read.
      fix[0] = 1'b1; fwe[0] = 1'b0; faddr[0] = 32'h100; pct[0] = 100; lim[0] = 1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         run(1);
         if (m_busy && !m_dma && (cyc - m_start) == 2) found = 1'b1;
      end
      chk("reached_wait", 32'(found), 1);
      if (found) do_reset();
      run(8);
      fix[0] = 1'b0;

      // Starvation count must restart from zero after reset.
      pct = '{100, 100}; lim = '{-1, -1};
      order_q.delete();
      run(32);
      pct = '{0, 0};
      run(12);
      ord = contended_order(6);
      chk("post_reset_order", 32'(ord[11:6]), 32'h03);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
